// File: rtl/data_ram_responder.sv
// data_ram_responder: word-organised synchronous data store that answers
// the memory-stage ena/wea/address/wdata requests of the core.
//
// Ports:
//   clka          clock, all state updates on the rising edge
//   rst           asynchronous active-low reset
//   data_ram_ena  request valid, accepted on every edge where it is 1
//   data_ram_wea  1 = write, 0 = read
//   alu_result    byte address, word index = alu_result[ADDR_W+1:2]
//   mem_wdata     write data
//   data_ram_bwe  byte-lane write enables (only with DATA_RAM_BYTE_EN)
//   mem_rdata     read data, valid while rvalid = 1, held otherwise
//   rvalid        one pulse per accepted read, LAT cycles after accept
//   misalign_err  one pulse per misaligned access, LAT cycles after accept
//   rd_count      accepted reads since reset
//   wr_count      accepted writes since reset (misaligned ones included)
//
// Optional build macro: DATA_RAM_BYTE_EN adds per-byte write enables.
module data_ram_responder #(
    parameter int DEPTH  = 1024,
    parameter int ADDR_W = 10,
    parameter int LAT    = 1
) (
    input  logic        clka,
    input  logic        rst,
    input  logic        data_ram_ena,
    input  logic        data_ram_wea,
    input  logic [31:0] alu_result,
    input  logic [31:0] mem_wdata,
`ifdef DATA_RAM_BYTE_EN
    input  logic [3:0]  data_ram_bwe,
`endif
    output logic [31:0] mem_rdata,
    output logic        rvalid,
    output logic        misalign_err,
    output logic [31:0] rd_count,
    output logic [31:0] wr_count
);

    logic [ADDR_W-1:0] idx;
    logic              mis;
    logic              acc_rd;
    logic              acc_wr;
    logic [3:0]        lane_en;

    assign idx    = alu_result[ADDR_W+1:2];
    assign mis    = |alu_result[1:0];
    assign acc_rd = data_ram_ena & ~data_ram_wea;
    assign acc_wr = data_ram_ena & data_ram_wea;

`ifdef DATA_RAM_BYTE_EN
    assign lane_en = data_ram_bwe;
`else
    assign lane_en = 4'hF;
`endif

    // Address bits above the word index alias onto the same words.
    logic unused_addr;
    assign unused_addr = ^alu_result[31:ADDR_W+2];

    // Storage is never reset.
    logic [31:0] mem [DEPTH];

    always_ff @(posedge clka) begin
        if (acc_wr && !mis) begin
            for (int b = 0; b < 4; b++) begin
                if (lane_en[b]) begin
                    mem[idx][8*b +: 8] <= mem_wdata[8*b +: 8];
                end
            end
        end
    end

    // Response pipeline: stage 0 is loaded at the accept edge, LAT-1
    // further stages follow. Data stages only load when a read moves
    // into them, so the last stage holds its value between responses.
    logic [LAT-1:0] v_q;
    logic [LAT-1:0] e_q;
    logic [31:0]    d_q [LAT];

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            v_q <= '0;
            e_q <= '0;
            for (int k = 0; k < LAT; k++) begin
                d_q[k] <= '0;
            end
        end else begin
            v_q[0] <= acc_rd;
            e_q[0] <= data_ram_ena & mis;
            if (acc_rd) begin
                d_q[0] <= mis ? 32'h0 : mem[idx];
            end
            for (int k = 1; k < LAT; k++) begin
                v_q[k] <= v_q[k-1];
                e_q[k] <= e_q[k-1];
                if (v_q[k-1]) begin
                    d_q[k] <= d_q[k-1];
                end
            end
        end
    end

    always_ff @(posedge clka or negedge rst) begin
        if (!rst) begin
            rd_count <= '0;
            wr_count <= '0;
        end else begin
            if (acc_rd) begin
                rd_count <= rd_count + 32'd1;
            end
            if (acc_wr) begin
                wr_count <= wr_count + 32'd1;
            end
        end
    end

    assign rvalid       = v_q[LAT-1];
    assign misalign_err = e_q[LAT-1];
    assign mem_rdata    = d_q[LAT-1];

endmodule

// File: tb/tb_data_ram_responder.sv
// tb_data_ram_responder: directed and random checks of data_ram_responder
// against a word-array reference model with a due-cycle response table.
module tb_data_ram_responder;

    localparam int DEPTH  = 1024;
    localparam int ADDR_W = 10;
    localparam int LAT    = 3;
`ifdef DATA_RAM_BYTE_EN
    localparam bit BE = 1'b1;
`else
    localparam bit BE = 1'b0;
`endif

    logic        clka = 1'b0;
    logic        rst = 1'b0;
    logic        data_ram_ena = 1'b0;
    logic        data_ram_wea = 1'b0;
    logic [31:0] alu_result = '0;
    logic [31:0] mem_wdata = '0;
    logic [3:0]  bwe = 4'hF;
    logic [31:0] mem_rdata;
    logic        rvalid;
    logic        misalign_err;
    logic [31:0] rd_count;
    logic [31:0] wr_count;

    data_ram_responder #(
        .DEPTH (DEPTH),
        .ADDR_W(ADDR_W),
        .LAT   (LAT)
    ) dut (
        .clka        (clka),
        .rst         (rst),
        .data_ram_ena(data_ram_ena),
        .data_ram_wea(data_ram_wea),
        .alu_result  (alu_result),
        .mem_wdata   (mem_wdata),
`ifdef DATA_RAM_BYTE_EN
        .data_ram_bwe(bwe),
`endif
        .mem_rdata   (mem_rdata),
        .rvalid      (rvalid),
        .misalign_err(misalign_err),
        .rd_count    (rd_count),
        .wr_count    (wr_count)
    );

    always #5 clka = ~clka;

    int checks = 0;
    int failures = 0;

    // Reference model state
    logic [31:0] mdl [DEPTH];
    bit   [3:0]  kn  [DEPTH];
    int          edge_n = 0;
    bit          exp_rv [int];
    bit          exp_e  [int];
    logic [31:0] exp_d  [int];
    bit          exp_dk [int];
    logic [31:0] last_d = '0;
    bit          last_k = 1'b1;
    logic [31:0] m_rd = '0;
    logic [31:0] m_wr = '0;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic model_clear();
        exp_rv.delete();
        exp_e.delete();
        exp_d.delete();
        exp_dk.delete();
        last_d = '0;
        last_k = 1'b1;
        m_rd = '0;
        m_wr = '0;
    endtask

    task automatic accept(input bit en, input bit we,
                          input logic [31:0] a, input logic [31:0] wd,
                          input logic [3:0] be);
        int          idx;
        bit          mis;
        int          due;
        logic [3:0]  mask;
        if (!en) return;
        idx  = int'(a[ADDR_W+1:2]);
        mis  = (a[1:0] != 2'b00);
        due  = edge_n + LAT - 1;
        mask = BE ? be : 4'hF;
        if (mis) exp_e[due] = 1'b1;
        if (we) begin
            m_wr++;
            if (!mis) begin
                for (int b = 0; b < 4; b++) begin
                    if (mask[b]) begin
                        mdl[idx][8*b +: 8] = wd[8*b +: 8];
                        kn[idx][b] = 1'b1;
                    end
                end
            end
        end else begin
            m_rd++;
            exp_rv[due] = 1'b1;
            exp_d[due]  = mis ? 32'h0 : mdl[idx];
            exp_dk[due] = mis || (kn[idx] == 4'hF);
        end
    endtask

    task automatic check_outputs();
        bit rv;
        bit er;
        rv = exp_rv.exists(edge_n);
        er = exp_e.exists(edge_n);
        if (rv) begin
            last_d = exp_d[edge_n];
            last_k = exp_dk[edge_n];
        end
        chk("rvalid", {31'h0, rvalid}, {31'h0, rv});
        chk("misalign_err", {31'h0, misalign_err}, {31'h0, er});
        if (last_k) chk("mem_rdata", mem_rdata, last_d);
        chk("rd_count", rd_count, m_rd);
        chk("wr_count", wr_count, m_wr);
    endtask

    task automatic step(input bit en, input bit we, input logic [31:0] a,
                        input logic [31:0] wd, input logic [3:0] be);
        @(negedge clka);
        data_ram_ena = en;
        data_ram_wea = we;
        alu_result   = a;
        mem_wdata    = wd;
        bwe          = be;
        @(posedge clka);
        #1;
        edge_n++;
        accept(en, we, a, wd, be);
        check_outputs();
    endtask

    task automatic wr(input logic [31:0] a, input logic [31:0] wd);
        step(1'b1, 1'b1, a, wd, 4'hF);
    endtask

    task automatic rd(input logic [31:0] a);
        step(1'b1, 1'b0, a, 32'h0, 4'hF);
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) step(1'b0, 1'b0, 32'h0, 32'h0, 4'h0);
    endtask

    task automatic do_reset();
        @(negedge clka);
        data_ram_ena = 1'b0;
        rst = 1'b0;
        #1;
        model_clear();
        chk("rst_rvalid", {31'h0, rvalid}, 32'h0);
        chk("rst_err", {31'h0, misalign_err}, 32'h0);
        chk("rst_rdata", mem_rdata, 32'h0);
        chk("rst_rd_count", rd_count, 32'h0);
        chk("rst_wr_count", wr_count, 32'h0);
        repeat (2) @(posedge clka);
        edge_n += 2;
        @(negedge clka);
        rst = 1'b1;
    endtask

    initial begin
        logic [31:0] a;
        logic [31:0] r;
        for (int i = 0; i < DEPTH; i++) kn[i] = 4'h0;

        do_reset();
        idle(2);

        // Read cut off by a reset before its response is due
        rd(32'h0000_0000);
        idle(1);
        do_reset();
        idle(LAT + 2);
        chk("after_rst_rd_count", rd_count, 32'h0);
        chk("after_rst_rdata", mem_rdata, 32'h0);

        // Preload word index values, then stream 8 reads
        for (int i = 0; i < 8; i++) wr(32'(i * 4), 32'(i));
        for (int i = 0; i < 8; i++) rd(32'(i * 4));
        idle(LAT + 1);
        chk("stream_rd_count", rd_count, 32'd8);

        // Write then read the next cycle
        wr(32'h10, 32'hDEAD_BEEF);
        rd(32'h10);
        idle(LAT + 1);
        chk("raw_rdata", mem_rdata, 32'hDEAD_BEEF);

        // Misaligned write leaves memory alone, misaligned read returns 0
        wr(32'h20, 32'hCAFE_F00D);
        wr(32'h21, 32'h1234_5678);
        rd(32'h20);
        rd(32'h22);
        idle(LAT + 1);

        // Aliasing through upper address bits
        wr(32'h1000, 32'hA5A5_A5A5);
        rd(32'h0000);
        idle(LAT + 1);
        chk("alias_rdata", mem_rdata, 32'hA5A5_A5A5);

        // Byte lanes (all lanes written when the feature is absent)
        wr(32'h30, 32'h1122_3344);
        step(1'b1, 1'b1, 32'h30, 32'hAABB_CCDD, 4'b0101);
        rd(32'h30);
        step(1'b1, 1'b1, 32'h30, 32'h0F0F_0F0F, 4'b0000);
        rd(32'h30);
        idle(LAT + 1);

        // Random traffic
        for (int n = 0; n < 400; n++) begin
            a = $urandom();
            r = $urandom();
            a[ADDR_W+1:2] = ADDR_W'($urandom_range(0, 15));
            if ($urandom_range(0, 4) != 0) a[1:0] = 2'b00;
            step(r[0] | r[1], r[2], a, $urandom(), r[7:4]);
        end
        idle(LAT + 1);

        // Reset after random traffic
        do_reset();
        idle(LAT + 1);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #1_000_000;
        $display("FAIL timeout observed=running expected=finished");
        $fatal(1, "timeout");
    end

endmodule
